axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- AXI4-Lite initiator that drives the waveform block's slave register ports (s_axi_lite_0/1) from a simple command/response interface.
- Used by local control logic and benches to issue single register writes and reads, one outstanding transaction at a time.
- Includes per-transaction timeout detection so a hung slave cannot stall the control path.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (fixed 32 in this design; STRB_W = DATA_W/8).
- TIMEOUT_CYCLES, 1024, cycles from first valid assertion to abort; 0 disables the timeout.

Ports:
- axi_lite_aclk_in  in  1  single clock for all logic.
- axi_lite_aresetn_in  in  1  asynchronous active-low reset.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accepted when high with cmd_valid_in.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_addr_in  in  ADDR_W  byte address.
- cmd_wdata_in  in  DATA_W  write data.
- cmd_wstrb_in  in  STRB_W  write strobes.
- rsp_valid_out  out  1  response available.
- rsp_ready_in  in  1  response consumed.
- rsp_rdata_out  out  DATA_W  read data; 0 for writes.
- rsp_resp_out  out  2  AXI BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout_out  out  1  response was generated by timeout.
- m_axi_awaddr_out, m_axi_awprot_out(3), m_axi_awvalid_out  out; m_axi_awready_in  in.
- m_axi_wdata_out, m_axi_wstrb_out, m_axi_wvalid_out  out; m_axi_wready_in  in.
- m_axi_bresp_in(2), m_axi_bvalid_in  in; m_axi_bready_out  out.
- m_axi_araddr_out, m_axi_arprot_out(3), m_axi_arvalid_out  out; m_axi_arready_in  in.
- m_axi_rdata_in, m_axi_rresp_in(2), m_axi_rvalid_in  in; m_axi_rready_out  out.

Behaviour:
- Reset state: all outputs 0 except cmd_ready_out = 1. FSM is in IDLE; timeout counter = 0. awprot/arprot are constant 3'b000.
- IDLE:
  - cmd_ready_out = 1. A handshake (cmd_valid_in & cmd_ready_out) registers addr/wdata/wstrb.
  - Write command goes to WR, read command goes to RD. cmd_ready_out drops the next cycle.
- WR:
  - awvalid and wvalid assert together in the cycle after acceptance.
  - Each valid drops independently in the cycle after its own ready is sampled high. aw and w handshakes may complete in either order or in the same cycle.
  - When both are done, go to WB.
- WB: bready = 1. On bvalid, capture bresp and go to RSP.
- RD: arvalid = 1 until arready; then go to RR.
- RR: rready = 1. On rvalid, capture rdata/rresp and go to RSP.
- Valid/ready rules:
  - Once asserted, a valid is never withdrawn before its handshake, except on timeout.
  - Address and data stay stable while their valid is high.
- RSP:
  - rsp_valid_out = 1, outputs held stable.
  - On rsp_ready_in, go to IDLE. cmd_ready_out rises the following cycle, so the minimum gap between commands is one cycle.
- Latency with a zero-wait slave:
  - Write: accept at T, aw/w at T+1, bvalid earliest T+2, rsp_valid T+3.
  - Read: arvalid T+1, rvalid earliest T+2, rsp_valid T+3.
- Timeout:
  - Counter clears on command accept and increments every cycle in WR/WB/RD/RR.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), all m_axi valids/readys deassert and the FSM goes to RSP with rsp_resp_out = 2'b10, rsp_timeout_out = 1, rsp_rdata_out = 0.
  - A late bvalid/rvalid arriving in RSP or IDLE is ignored (bready/rready are 0).
  - This path is error recovery only; it is not AXI-compliant abort.
- SLVERR/DECERR from the slave pass through unchanged, with rsp_timeout_out = 0.
- Asynchronous reset mid-transaction: immediately return to the reset state. No response is generated for the in-flight command.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, WR, WB, RD, RR, RSP (3 bits).
  - AXI response constants: OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
  - Default PROT value 3'b000.
- No sub-module needed; the timeout counter stays inline.

Test Plan:
- Write 0x12345678 to addr 0x04, wstrb 0xF, zero-wait slave -> aw/w valid at T+1, rsp at T+3 with resp 0, rdata 0; slave register reads back 0x12345678.
- Read addr 0x04 with slave arready delayed 3 cycles and rvalid 2 more -> arvalid held stable 4 cycles; rsp_rdata 0x12345678, resp 0.
- Write with wready before awready (w at T+1, aw at T+4) -> wvalid drops at T+2, awvalid at T+5, bready then asserted; single rsp.
- TIMEOUT_CYCLES = 16, slave never asserts arready -> arvalid drops after 16 cycles; rsp resp 2'b10, timeout = 1; next command accepted.
- Slave returns rresp 2'b11 on read -> rsp_resp 2'b11, timeout 0; rsp held while rsp_ready low for 5 cycles, cmd_ready stays 0.
- Assert axi_lite_aresetn_in low during WB -> all m_axi outputs 0 and cmd_ready 1 immediately; no rsp_valid after release.

Source files
------------

// File: rtl/axil_cmd_master_pkg.sv
// =============================================================================
// axil_cmd_master_pkg : FSM encoding, AXI response codes and helpers  (rev 1.0)
// =============================================================================
`default_nettype none

package axil_cmd_master_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_WB   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_RR   = 3'd4;
  localparam logic [2:0] ST_RSP  = 3'd5;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // A timed-out transaction is reported to the requester as a slave error
  localparam logic [1:0] RESP_TIMEOUT = RESP_SLVERR;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_WR) || (st == ST_WB) || (st == ST_RD) || (st == ST_RR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_cmd_master.sv
// =============================================================================
// axil_cmd_master : single-outstanding AXI4-Lite initiator with timeout  (rev 1.0)
// =============================================================================
`default_nettype none

module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_W        = DATA_W / 8
) (
  input  logic              axi_lite_aclk_in,
  input  logic              axi_lite_aresetn_in,

  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic              cmd_write_in,
  input  logic [ADDR_W-1:0] cmd_addr_in,
  input  logic [DATA_W-1:0] cmd_wdata_in,
  input  logic [STRB_W-1:0] cmd_wstrb_in,

  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_rdata_out,
  output logic [1:0]        rsp_resp_out,
  output logic              rsp_timeout_out,

  output logic [ADDR_W-1:0] m_axi_awaddr_out,
  output logic [2:0]        m_axi_awprot_out,
  output logic              m_axi_awvalid_out,
  input  logic              m_axi_awready_in,

  output logic [DATA_W-1:0] m_axi_wdata_out,
  output logic [STRB_W-1:0] m_axi_wstrb_out,
  output logic              m_axi_wvalid_out,
  input  logic              m_axi_wready_in,

  input  logic [1:0]        m_axi_bresp_in,
  input  logic              m_axi_bvalid_in,
  output logic              m_axi_bready_out,

  output logic [ADDR_W-1:0] m_axi_araddr_out,
  output logic [2:0]        m_axi_arprot_out,
  output logic              m_axi_arvalid_out,
  input  logic              m_axi_arready_in,

  input  logic [DATA_W-1:0] m_axi_rdata_in,
  input  logic [1:0]        m_axi_rresp_in,
  input  logic              m_axi_rvalid_in,
  output logic              m_axi_rready_out
);

  // Counter only has to reach TIMEOUT_CYCLES-1; the abort fires on that value
  localparam int             CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              arvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  to_cnt;

  logic              cmd_fire;
  logic              to_hit;
  logic              aw_done;
  logic              w_done;

  assign cmd_fire = cmd_valid_in && (state == ST_IDLE);
  assign to_hit   = (TIMEOUT_CYCLES != 0) && is_busy(state) && (to_cnt == TO_LAST);
  // A channel counts as done if already finished or handshaking this cycle
  assign aw_done  = !awvalid_q || m_axi_awready_in;
  assign w_done   = !wvalid_q  || m_axi_wready_in;

  always_ff @(posedge axi_lite_aclk_in or negedge axi_lite_aresetn_in) begin
    if (!axi_lite_aresetn_in) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
      to_cnt    <= '0;
    end else begin
      if (is_busy(state)) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end

      if (to_hit) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rdata_q   <= '0;
        resp_q    <= RESP_TIMEOUT;
        timeout_q <= 1'b1;
        state     <= ST_RSP;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_fire) begin
              addr_q    <= cmd_addr_in;
              wdata_q   <= cmd_wdata_in;
              wstrb_q   <= cmd_wstrb_in;
              rdata_q   <= '0;
              resp_q    <= RESP_OKAY;
              timeout_q <= 1'b0;
              to_cnt    <= '0;
              if (cmd_write_in) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state     <= ST_WR;
              end else begin
                arvalid_q <= 1'b1;
                state     <= ST_RD;
              end
            end
          end

          ST_WR: begin
            if (awvalid_q && m_axi_awready_in) begin
              awvalid_q <= 1'b0;
            end
            if (wvalid_q && m_axi_wready_in) begin
              wvalid_q <= 1'b0;
            end
            if (aw_done && w_done) begin
              state <= ST_WB;
            end
          end

          ST_WB: begin
            if (m_axi_bvalid_in) begin
              resp_q <= m_axi_bresp_in;
              state  <= ST_RSP;
            end
          end

          ST_RD: begin
            if (m_axi_arready_in) begin
              arvalid_q <= 1'b0;
              state     <= ST_RR;
            end
          end

          ST_RR: begin
            if (m_axi_rvalid_in) begin
              rdata_q <= m_axi_rdata_in;
              resp_q  <= m_axi_rresp_in;
              state   <= ST_RSP;
            end
          end

          ST_RSP: begin
            if (rsp_ready_in) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready_out     = (state == ST_IDLE);

  assign rsp_valid_out     = (state == ST_RSP);
  assign rsp_rdata_out     = rdata_q;
  assign rsp_resp_out      = resp_q;
  assign rsp_timeout_out   = timeout_q;

  assign m_axi_awaddr_out  = addr_q;
  assign m_axi_awprot_out  = PROT_DEFAULT;
  assign m_axi_awvalid_out = awvalid_q;

  assign m_axi_wdata_out   = wdata_q;
  assign m_axi_wstrb_out   = wstrb_q;
  assign m_axi_wvalid_out  = wvalid_q;

  assign m_axi_bready_out  = (state == ST_WB);

  assign m_axi_araddr_out  = addr_q;
  assign m_axi_arprot_out  = PROT_DEFAULT;
  assign m_axi_arvalid_out = arvalid_q;

  assign m_axi_rready_out  = (state == ST_RR);

endmodule

`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
// =============================================================================
// tb_axil_cmd_master : directed self-checking bench for axil_cmd_master  (rev 1.0)
// =============================================================================
`default_nettype none

module tb_axil_cmd_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic [1:0]        bresp, rresp;

  logic [4:0]        hs;
  assign hs = {awvalid, wvalid, arvalid, bready, rready};

  int vectors    = 0;
  int miscompares = 0;

  // Slave-side bookkeeping: captured write address/data and handshake counts
  logic [DATA_W-1:0] mem [0:15];
  logic [ADDR_W-1:0] seen_awaddr;
  logic [DATA_W-1:0] seen_wdata;
  int                aw_hs_cnt = 0;
  int                w_hs_cnt  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid && awready) begin
      seen_awaddr <= awaddr;
      aw_hs_cnt   <= aw_hs_cnt + 1;
    end
    if (wvalid && wready) begin
      seen_wdata <= wdata;
      w_hs_cnt   <= w_hs_cnt + 1;
    end
  end

  axil_cmd_master #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .axi_lite_aclk_in    (clk),
    .axi_lite_aresetn_in (rstn),
    .cmd_valid_in        (cmd_valid),
    .cmd_ready_out       (cmd_ready),
    .cmd_write_in        (cmd_write),
    .cmd_addr_in         (cmd_addr),
    .cmd_wdata_in        (cmd_wdata),
    .cmd_wstrb_in        (cmd_wstrb),
    .rsp_valid_out       (rsp_valid),
    .rsp_ready_in        (rsp_ready),
    .rsp_rdata_out       (rsp_rdata),
    .rsp_resp_out        (rsp_resp),
    .rsp_timeout_out     (rsp_timeout),
    .m_axi_awaddr_out    (awaddr),
    .m_axi_awprot_out    (awprot),
    .m_axi_awvalid_out   (awvalid),
    .m_axi_awready_in    (awready),
    .m_axi_wdata_out     (wdata),
    .m_axi_wstrb_out     (wstrb),
    .m_axi_wvalid_out    (wvalid),
    .m_axi_wready_in     (wready),
    .m_axi_bresp_in      (bresp),
    .m_axi_bvalid_in     (bvalid),
    .m_axi_bready_out    (bready),
    .m_axi_araddr_out    (araddr),
    .m_axi_arprot_out    (arprot),
    .m_axi_arvalid_out   (arvalid),
    .m_axi_arready_in    (arready),
    .m_axi_rdata_in      (rdata),
    .m_axi_rresp_in      (rresp),
    .m_axi_rvalid_in     (rvalid),
    .m_axi_rready_out    (rready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_accept;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    vectors++;
    if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: got %b expected 0000", {rsp_valid, rsp_timeout, rsp_resp});
    end
    vectors++;
    if (hs !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got %b expected 00000", hs);
    end
    vectors++;
    if ({awprot, arprot, awaddr, araddr, wdata, wstrb, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: awaddr %h wdata %h rsp_rdata %h prot %b/%b expected zero",
               awaddr, wdata, rsp_rdata, awprot, arprot);
    end
  endtask

  task automatic test_write_zero_wait;
    issue(1'b1, 32'h04, 32'h1234_5678, 4'hF);
    vectors++;
    if ({hs, cmd_ready} !== 6'b110000) begin
      miscompares++;
      $display("FAIL wr_t1_valids: got %b expected 110000", {hs, cmd_ready});
    end
    vectors++;
    if ({awaddr, wdata, wstrb} !== {32'h04, 32'h1234_5678, 4'hF}) begin
      miscompares++;
      $display("FAIL wr_t1_payload: got %h %h %h expected 4 12345678 f", awaddr, wdata, wstrb);
    end
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    vectors++;
    if ({hs, rsp_valid} !== 6'b000100) begin
      miscompares++;
      $display("FAIL wr_t2_bready: got %b expected 000100", {hs, rsp_valid});
    end
    mem[seen_awaddr[5:2]] = seen_wdata;
    bvalid = 1'b1;
    bresp  = 2'b00;
    tick();
    bvalid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b00, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL wr_t3_rsp: got v%b r%b t%b d%h expected v1 r00 t0 d0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    vectors++;
    if (mem[1] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL wr_slave_reg: got %h expected 12345678", mem[1]);
    end
    rsp_accept();
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL wr_back_idle: got %b expected 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read_delayed;
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if ({arvalid, araddr, rready} !== {1'b1, 32'h04, 1'b0}) begin
        miscompares++;
        $display("FAIL rd_ar_hold cycle %0d: got arvalid %b araddr %h rready %b expected 1 4 0",
                 i, arvalid, araddr, rready);
      end
      if (i == 4) arready = 1'b1;
      tick();
    end
    arready = 1'b0;
    vectors++;
    if (hs !== 5'b00001) begin
      miscompares++;
      $display("FAIL rd_t5_rready: got %b expected 00001", hs);
    end
    tick();
    vectors++;
    if ({hs, rsp_valid} !== 6'b000010) begin
      miscompares++;
      $display("FAIL rd_t6_wait: got %b expected 000010", {hs, rsp_valid});
    end
    rvalid = 1'b1;
    rdata  = mem[araddr[5:2]];
    rresp  = 2'b00;
    tick();
    rvalid = 1'b0;
    rdata  = '0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b00, 1'b0, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL rd_rsp: got v%b r%b t%b d%h expected v1 r00 t0 d12345678",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    rsp_accept();
  endtask

  task automatic test_w_before_aw;
    int aw0 = aw_hs_cnt;
    int w0  = w_hs_cnt;
    logic [4:0] exp_hs [1:4] = '{5'b11000, 5'b10000, 5'b10000, 5'b10000};
    issue(1'b1, 32'h08, 32'hA5A5_5A5A, 4'h3);
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (hs !== exp_hs[i]) begin
        miscompares++;
        $display("FAIL wfirst_t%0d: got %b expected %b", i, hs, exp_hs[i]);
      end
      wready  = (i == 1);
      awready = (i == 4);
      tick();
    end
    wready  = 1'b0;
    awready = 1'b0;
    vectors++;
    if (hs !== 5'b00010) begin
      miscompares++;
      $display("FAIL wfirst_t5_bready: got %b expected 00010", hs);
    end
    mem[seen_awaddr[5:2]] = seen_wdata;
    bvalid = 1'b1;
    bresp  = 2'b00;
    tick();
    bvalid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wfirst_rsp: got %b expected 1000", {rsp_valid, rsp_resp, rsp_timeout});
    end
    rsp_accept();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL wfirst_single_rsp cycle %0d: got %b expected 0", i, rsp_valid);
      end
      tick();
    end
    vectors++;
    if ({aw_hs_cnt - aw0, w_hs_cnt - w0} !== {32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL wfirst_hs_count: got aw %0d w %0d expected 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    vectors++;
    if (mem[2] !== 32'hA5A5_5A5A) begin
      miscompares++;
      $display("FAIL wfirst_slave_reg: got %h expected a5a55a5a", mem[2]);
    end
  endtask

  task automatic test_timeout;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    for (int i = 1; i < 16; i++) tick();
    vectors++;
    if ({arvalid, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL to_t16_still_waiting: got %b expected 10", {arvalid, rsp_valid});
    end
    tick();
    vectors++;
    if (hs !== 5'b0) begin
      miscompares++;
      $display("FAIL to_t17_valids_drop: got %b expected 00000", hs);
    end
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b10, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL to_rsp: got v%b r%b t%b d%h expected v1 r10 t1 d0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    rvalid = 1'b1;
    rdata  = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (rready !== 1'b0) begin
      miscompares++;
      $display("FAIL to_late_rvalid_rsp: got rready %b expected 0", rready);
    end
    rsp_accept();
    vectors++;
    if ({cmd_ready, rready, rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL to_late_rvalid_idle: got %b expected 100", {cmd_ready, rready, rsp_valid});
    end
    rvalid = 1'b0;
    rdata  = '0;
    issue(1'b1, 32'h0C, 32'h0BAD_F00D, 4'hF);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    bresp   = 2'b00;
    tick();
    bvalid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000) begin
      miscompares++;
      $display("FAIL to_next_cmd_rsp: got %b expected 1000", {rsp_valid, rsp_resp, rsp_timeout});
    end
    rsp_accept();
  endtask

  task automatic test_rresp_decerr;
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    rresp   = 2'b11;
    tick();
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, cmd_ready, rsp_resp, rsp_timeout, rsp_rdata} !==
          {1'b1, 1'b0, 2'b11, 1'b0, 32'hDEAD_BEEF}) begin
        miscompares++;
        $display("FAIL decerr_hold cycle %0d: got v%b cr%b r%b t%b d%h expected v1 cr0 r11 t0 ddeadbeef",
                 i, rsp_valid, cmd_ready, rsp_resp, rsp_timeout, rsp_rdata);
      end
      tick();
    end
    rsp_accept();
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL decerr_release: got %b expected 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 32'h14, 32'h1122_3344, 4'h1);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    bresp   = 2'b10;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b10, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL b2b_slverr_rsp: got v%b r%b t%b d%h expected v1 r10 t0 d0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    rsp_accept();
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap: got cmd_ready %b expected 1", cmd_ready);
    end
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    vectors++;
    if ({arvalid, araddr, cmd_ready} !== {1'b1, 32'h20, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_read_issue: got arvalid %b araddr %h cmd_ready %b expected 1 20 0",
               arvalid, araddr, cmd_ready);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h55AA_0000;
    rresp   = 2'b10;
    tick();
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = 2'b00;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b10, 1'b0, 32'h55AA_0000}) begin
      miscompares++;
      $display("FAIL b2b_read_rsp: got v%b r%b t%b d%h expected v1 r10 t0 d55aa0000",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    rsp_accept();
  endtask

  task automatic test_reset_in_wb;
    issue(1'b1, 32'h18, 32'hCAFE_0001, 4'hF);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    vectors++;
    if (hs !== 5'b00010) begin
      miscompares++;
      $display("FAIL rst_pre_wb: got %b expected 00010", hs);
    end
    #1;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({hs, cmd_ready, rsp_valid} !== 7'b0000010) begin
      miscompares++;
      $display("FAIL rst_async_ctrl: got %b expected 0000010", {hs, cmd_ready, rsp_valid});
    end
    vectors++;
    if ({awaddr, wdata, wstrb} !== '0) begin
      miscompares++;
      $display("FAIL rst_async_data: got %h %h %h expected 0 0 0", awaddr, wdata, wstrb);
    end
    tick();
    #2;
    rstn   = 1'b1;
    bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({rsp_valid, bready, cmd_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL rst_no_rsp cycle %0d: got %b expected 001", i, {rsp_valid, bready, cmd_ready});
      end
    end
    bvalid = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick();
    tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_write_zero_wait();
    test_read_delayed();
    test_w_before_aw();
    test_timeout();
    test_rresp_decerr();
    test_back_to_back();
    test_reset_in_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
